// File: rtl/seq_shift_mul_if.sv
// Handshake bundle for seq_shift_mul: operand channel in, product channel out.
interface seq_shift_mul_if #(
  parameter int WIDTH = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] y;
  logic               fast;
  logic               busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, fast, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, fast, busy
  );
endinterface

// File: rtl/seq_shift_mul.sv
// Multi-cycle unsigned WIDTH x WIDTH multiplier. Zero / power-of-two operands
// resolve to one shift; everything else retires STEP multiplier bits per cycle.
module seq_shift_mul #(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int FAST_PATH = 1
) (
  input logic           clk,
  input logic           rst_n,
  seq_shift_mul_if.slave bus
);
  localparam int ITER = WIDTH / STEP;
  localparam int CW   = $clog2(ITER) + 1;
  localparam int W2   = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [W2-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     y_q, y_d;
  logic              fast_q, fast_d;

  logic [W2-1:0]     pp [STEP];
  logic [W2-1:0]     step_sum;
  logic              fast_hit;
  logic [W2-1:0]     fast_y;
  logic              a_onehot, b_onehot;

  // One gated, pre-shifted copy of the multiplicand per retired multiplier bit.
  for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
    assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
  end

  // Accumulator value after this RUN cycle.
  always_comb begin
    step_sum = acc_q;
    for (int k = 0; k < STEP; k++) begin
      step_sum = step_sum + pp[k];
    end
  end

  // Fast-path classification of the offered operands, priority zero > a > b.
  always_comb begin
    fast_hit = 1'b0;
    fast_y   = '0;
    a_onehot = (bus.a != '0) && ((bus.a & (bus.a - WIDTH'(1))) == '0);
    b_onehot = (bus.b != '0) && ((bus.b & (bus.b - WIDTH'(1))) == '0);
    if (FAST_PATH != 0) begin
      if (bus.a == '0 || bus.b == '0) begin
        fast_hit = 1'b1;
      end else if (a_onehot) begin
        fast_hit = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
          if (bus.a[k]) fast_y = {{WIDTH{1'b0}}, bus.b} << k;
        end
      end else if (b_onehot) begin
        fast_hit = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
          if (bus.b[k]) fast_y = {{WIDTH{1'b0}}, bus.a} << k;
        end
      end
    end
  end

  // Next-state and datapath updates for IDLE/RUN/DONE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    fast_d   = fast_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (fast_hit) begin
            y_d     = fast_y;
            fast_d  = 1'b1;
            state_d = DONE;
          end else begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            cnt_d    = '0;
            fast_d   = 1'b0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + CW'(1);
        // Fixed ITER-cycle latency: no early exit when the multiplier empties.
        if (cnt_q == CW'(ITER - 1)) begin
          y_d     = step_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      fast_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      fast_q   <= fast_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.y         = y_q;
  assign bus.fast      = fast_q;
endmodule
